fp_adder_arbiter: RTL and testbench
===================================

Name: fp_adder_arbiter

Overview:
- Shares one combinational floating_point_adder instance between NUM_REQUESTERS independent requesters, using a round-robin arbiter and valid/ready handshakes.
- Registers the winning result, its requester ID and its exception flags in a single-entry output buffer that honours backpressure.
- Keeps sticky exception flags readable by the control path.
- Sits between compute clients (e.g. accumulators, dot-product sequencers) and the shared adder datapath.

Parameters:
- EXPONENT_WIDTH, 8, exponent width passed to the adder
- MANTISSA_WIDTH, 23, mantissa width passed to the adder
- NUM_REQUESTERS, 4, number of requesters (>=2)
- Localparams: FLOAT_BIT_WIDTH = EXPONENT_WIDTH+MANTISSA_WIDTH+1; ID_WIDTH = max(1, $clog2(NUM_REQUESTERS))

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQUESTERS  per-requester operation valid
- req_ready  output  NUM_REQUESTERS  per-requester accept; one-hot or zero
- req_a  input  NUM_REQUESTERS*FLOAT_BIT_WIDTH  packed operand A; requester i occupies slice i
- req_b  input  NUM_REQUESTERS*FLOAT_BIT_WIDTH  packed operand B
- req_subtract  input  NUM_REQUESTERS  1 = a-b, 0 = a+b
- out_valid  output  1  result buffer holds a result
- out_ready  input  1  consumer accepts the result
- out_result  output  FLOAT_BIT_WIDTH  registered adder result
- out_id  output  ID_WIDTH  index of the requester that produced out_result
- out_flags  output  3  {underflow, overflow, invalid} for out_result
- sticky_flags  output  3  OR of out_flags over all accepted operations since last clear
- clear_flags  input  1  clears sticky_flags
- busy  output  1  high while out_valid is high or any req_valid is high

Behaviour:
- Reset (rst=1 at an edge): out_valid=0; out_result=0; out_id=0; out_flags=0; sticky_flags=0; round-robin pointer=NUM_REQUESTERS-1 (requester 0 has first priority).
  - rst overrides every other input.
  - A pending result is discarded on reset and is never delivered.
  - req_ready is combinationally 0 while rst=1.
- Buffer states: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_accept = !out_valid || out_ready (combinational).
- Grant (combinational):
  - When can_accept, grant the first i with req_valid[i]=1, searching from pointer+1 and wrapping modulo NUM_REQUESTERS.
  - req_ready = one-hot of the grant; all zero when !can_accept or when no req_valid is high.
- The granted slice drives the adder inputs. Adder outputs are not registered inside the adder.
- On an edge with a grant (fire):
  - out_result, out_flags and out_id are loaded; out_valid=1; pointer=granted index.
  - Latency: one cycle from req_valid&&req_ready to out_valid.
- On an edge with out_valid && out_ready and no grant: out_valid=0.
- Simultaneous drain and grant: the buffer reloads in the same cycle. Throughput is one operation per cycle while out_ready stays high.
- FULL && !out_ready:
  - out_result, out_id and out_flags hold stable.
  - All req_ready=0.
  - The pointer does not move.
- Requester obligations:
  - A requester must hold req_valid and its operands stable until it receives ready.
  - The block never drops an asserted request.
  - Fairness: a continuously valid requester is granted within NUM_REQUESTERS grants.
- sticky_flags:
  - Each fire ORs the new flags into sticky_flags.
  - clear_flags zeroes sticky_flags.
  - clear_flags and fire in the same cycle: sticky_flags = new flags only (set wins over the old value).
- The adder treats NaN, Inf and zero exactly as its own specification defines. This block adds no arithmetic of its own.

Test Plan:
- Single requester 0: a=0x40400000, b=0x40800000, sub=0 -> req_ready[0] high in the same cycle; next cycle out_valid=1, out_result=0x40E00000, out_id=0, out_flags=0.
- All four requesters valid continuously, out_ready=1 -> out_id sequence 0,1,2,3,0,… with one result per cycle; a second run starting with the pointer at 2 yields 3,0,1,2.
- Backpressure: out_ready=0 for 5 cycles with requesters 1 and 2 valid -> out_result and out_id held; req_ready=0 throughout; after out_ready=1, both requests complete in order 1, 2 and none is lost.
- Exceptions: requester 3 sends a=0xFF800000, b=0x7F800000 -> out_result=0xFFC00000, out_flags=3'b001, sticky_flags=3'b001. Then +Inf+3.0 -> sticky_flags=3'b011. Then clear_flags together with a 3.0+4.0 fire -> sticky_flags=0.
- clear_flags in the same cycle as an invalid-operation fire -> sticky_flags=3'b001 afterwards.
- Reset mid-operation: out_valid=1 with out_ready=0, then rst pulsed for one cycle -> out_valid=0, out_result=0, sticky_flags=0; the next grant goes to the lowest valid index (requester 0 if valid).

Source files
------------

// File: rtl/fp_adder_arbiter.sv
// Shares one combinational floating-point adder between several requesters through a
// round-robin arbiter, with a single-entry result buffer and sticky exception flags.

module floating_point_adder #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
  input  logic                                   subtract,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] result,
  output logic [2:0]                             flags
);
  // Round-to-nearest-even. flags = {underflow, overflow, invalid}: overflow is raised
  // for any infinite result, underflow for an inexact subnormal result, invalid for Inf-Inf.
  localparam int E    = EXPONENT_WIDTH;
  localparam int M    = MANTISSA_WIDTH;
  localparam int FW   = E + M + 1;
  localparam int XW   = M + 4;
  localparam int EMAX = (1 << E) - 1;

  logic a_nan, b_nan, a_inf, b_inf, sb_eff;
  assign a_nan  = (&a[FW-2:M]) && (|a[M-1:0]);
  assign b_nan  = (&b[FW-2:M]) && (|b[M-1:0]);
  assign a_inf  = (&a[FW-2:M]) && !(|a[M-1:0]);
  assign b_inf  = (&b[FW-2:M]) && !(|b[M-1:0]);
  assign sb_eff = b[FW-1] ^ subtract;

  always_comb begin
    logic          swap, eff_sub, rnd_up, inexact, sgn;
    logic [FW-1:0] x, y;
    logic [XW-1:0] mx, my, lost, norm;
    logic [XW:0]   sum;
    logic [M+1:0]  mant;
    int            ex, ey, diff, lz, sh, er;
    result = '0;
    flags  = 3'b000;
    swap   = b[FW-2:0] > a[FW-2:0];
    x      = swap ? {sb_eff, b[FW-2:0]} : a;
    y      = swap ? a : {sb_eff, b[FW-2:0]};
    ex     = (x[FW-2:M] == '0) ? 1 : int'(x[FW-2:M]);
    ey     = (y[FW-2:M] == '0) ? 1 : int'(y[FW-2:M]);
    mx     = {|x[FW-2:M], x[M-1:0], 3'b000};
    my     = {|y[FW-2:M], y[M-1:0], 3'b000};
    diff   = ex - ey;
    if (diff >= XW) begin
      lost = my;
      my   = '0;
    end else begin
      lost = my << (XW - diff);
      my   = my >> diff;
    end
    my[0]   = my[0] | (|lost);
    eff_sub = x[FW-1] ^ y[FW-1];
    sum     = eff_sub ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});
    sgn     = (sum == '0) ? (x[FW-1] & ~eff_sub) : x[FW-1];
    lz      = XW;
    sh      = 0;
    if (sum[XW]) begin
      norm    = sum[XW:1];
      norm[0] = norm[0] | sum[0];
      er      = ex + 1;
    end else begin
      for (int i = 0; i < XW; i++) if (sum[i]) lz = XW - 1 - i;
      // Stop normalising at the minimum exponent so tiny results stay subnormal.
      sh   = (lz < ex - 1) ? lz : ex - 1;
      norm = sum[XW-1:0] << sh;
      er   = ex - sh;
    end
    rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    inexact = |norm[2:0];
    mant    = {1'b0, norm[XW-1:3]} + (M+2)'(rnd_up);
    if (mant[M+1]) begin
      mant = mant >> 1;
      er   = er + 1;
    end
    if (er >= EMAX) begin
      result = {sgn, {E{1'b1}}, {M{1'b0}}};
      flags  = 3'b010;
    end else begin
      result = {sgn, (mant[M] ? E'(er) : {E{1'b0}}), mant[M-1:0]};
      flags  = {~mant[M] & inexact, 2'b00};
    end
    if (a_nan || b_nan) begin
      result = {1'b1, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
      flags  = 3'b000;
    end else if (a_inf && b_inf && (a[FW-1] != sb_eff)) begin
      result = {1'b1, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
      flags  = 3'b001;
    end else if (a_inf) begin
      result = {a[FW-1], {E{1'b1}}, {M{1'b0}}};
      flags  = 3'b010;
    end else if (b_inf) begin
      result = {sb_eff, {E{1'b1}}, {M{1'b0}}};
      flags  = 3'b010;
    end
  end
endmodule

module fp_adder_arbiter #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int NUM_REQUESTERS = 4,
  localparam int FLOAT_BIT_WIDTH = EXPONENT_WIDTH + MANTISSA_WIDTH + 1,
  localparam int ID_WIDTH = (NUM_REQUESTERS > 2) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_REQUESTERS-1:0]                 req_valid,
  output logic [NUM_REQUESTERS-1:0]                 req_ready,
  input  logic [NUM_REQUESTERS*FLOAT_BIT_WIDTH-1:0] req_a,
  input  logic [NUM_REQUESTERS*FLOAT_BIT_WIDTH-1:0] req_b,
  input  logic [NUM_REQUESTERS-1:0]                 req_subtract,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [FLOAT_BIT_WIDTH-1:0]                out_result,
  output logic [ID_WIDTH-1:0]                       out_id,
  output logic [2:0]                                out_flags,
  output logic [2:0]                                sticky_flags,
  input  logic                                      clear_flags,
  output logic                                      busy
);
  // Handshake: a request transfers on an edge where req_valid[i] && req_ready[i];
  // the result transfers on an edge where out_valid && out_ready.
  typedef enum logic {EMPTY, FULL} buf_state_t;

  buf_state_t                 state;
  logic [ID_WIDTH-1:0]        ptr, gnt_idx;
  logic                       found, can_accept, fire;
  logic [FLOAT_BIT_WIDTH-1:0] op_a, op_b, sum_result;
  logic [2:0]                 sum_flags;

  assign out_valid  = (state == FULL);
  assign can_accept = !out_valid || out_ready;
  assign busy       = out_valid || (|req_valid);

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NUM_REQUESTERS; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % NUM_REQUESTERS]) begin
        found   = 1'b1;
        gnt_idx = ID_WIDTH'((int'(ptr) + k) % NUM_REQUESTERS);
      end
    end
  end

  assign fire      = can_accept && found && !rst;
  assign req_ready = fire ? (NUM_REQUESTERS'(1) << gnt_idx) : '0;
  assign op_a      = req_a[int'(gnt_idx)*FLOAT_BIT_WIDTH +: FLOAT_BIT_WIDTH];
  assign op_b      = req_b[int'(gnt_idx)*FLOAT_BIT_WIDTH +: FLOAT_BIT_WIDTH];

  floating_point_adder #(
    .EXPONENT_WIDTH(EXPONENT_WIDTH),
    .MANTISSA_WIDTH(MANTISSA_WIDTH)
  ) u_adder (
    .a        (op_a),
    .b        (op_b),
    .subtract (req_subtract[gnt_idx]),
    .result   (sum_result),
    .flags    (sum_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      out_result   <= '0;
      out_id       <= '0;
      out_flags    <= 3'b000;
      sticky_flags <= 3'b000;
      ptr          <= ID_WIDTH'(NUM_REQUESTERS - 1);
    end else begin
      if (fire) begin
        state      <= FULL;
        out_result <= sum_result;
        out_id     <= gnt_idx;
        out_flags  <= sum_flags;
        ptr        <= gnt_idx;
      end else if (out_ready) begin
        state <= EMPTY;
      end
      // A clear coinciding with a fire keeps only the new flags.
      sticky_flags <= (clear_flags ? 3'b000 : sticky_flags) | (fire ? sum_flags : 3'b000);
    end
  end
endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Directed bench for fp_adder_arbiter: arbitration order, backpressure, exceptions and reset.

module tb_fp_adder_arbiter;
  localparam int N   = 4;
  localparam int FW  = 32;
  localparam int IDW = 2;

  localparam logic [31:0] F1   = 32'h3F800000;
  localparam logic [31:0] F2   = 32'h40000000;
  localparam logic [31:0] F3   = 32'h40400000;
  localparam logic [31:0] F4   = 32'h40800000;
  localparam logic [31:0] F6   = 32'h40C00000;
  localparam logic [31:0] F7   = 32'h40E00000;
  localparam logic [31:0] F8   = 32'h41000000;
  localparam logic [31:0] PINF = 32'h7F800000;
  localparam logic [31:0] NINF = 32'hFF800000;
  localparam logic [31:0] QNAN = 32'hFFC00000;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_subtract;
  logic [N*FW-1:0] req_a, req_b;
  logic            out_valid, out_ready, clear_flags, busy;
  logic [FW-1:0]   out_result;
  logic [IDW-1:0]  out_id;
  logic [2:0]      out_flags, sticky_flags;

  int n_checks = 0;
  int n_fail   = 0;
  logic [IDW-1:0] exp_q[$];

  always #5 clk = ~clk;

  fp_adder_arbiter #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .NUM_REQUESTERS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_subtract (req_subtract),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_id       (out_id),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .clear_flags  (clear_flags),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic sub);
    req_a[i*FW +: FW]  = a;
    req_b[i*FW +: FW]  = b;
    req_subtract[i]    = sub;
  endtask

  task automatic expect_id_run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      tick();
      check("run_valid", 32'(out_valid), 32'd1);
      check("run_result", out_result, F2);
      if (exp_q.size() == 0) check("run_queue_empty", 32'd1, 32'd0);
      else check("run_id", 32'(out_id), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_subtract = '0;
    out_ready = 1'b0; clear_flags = 1'b0;

    // Reset state and reset gating of req_ready
    tick();
    req_valid = 4'hF;
    #1 check("rst_ready", 32'(req_ready), 32'd0);
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_id", 32'(out_id), 32'd0);
    check("rst_flags", 32'(out_flags), 32'd0);
    check("rst_sticky", 32'(sticky_flags), 32'd0);
    req_valid = '0;
    rst = 1'b0;
    #1 check("idle_busy", 32'(busy), 32'd0);

    // Single requester 0: 3.0 + 4.0
    set_req(0, F3, F4, 1'b0);
    req_valid = 4'b0001;
    out_ready = 1'b1;
    #1 check("t1_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_result", out_result, F7);
    check("t1_id", 32'(out_id), 32'd0);
    check("t1_flags", 32'(out_flags), 32'd0);
    tick();
    check("t1_drain", 32'(out_valid), 32'd0);

    // Round robin from a fresh reset: 0,1,2,3,0,1,2,3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, F1, F1, 1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(IDW'(i % N));
    req_valid = 4'hF;
    expect_id_run(8);
    req_valid = '0;
    tick();
    check("rr_drain", 32'(out_valid), 32'd0);
    // Move pointer to 2, then expect 3,0,1,2
    req_valid = 4'b0100;
    tick();
    check("rr_ptr2_id", 32'(out_id), 32'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    req_valid = 4'hF;
    expect_id_run(4);
    req_valid = '0;
    tick();

    // Backpressure with requesters 1 and 2 (pointer at 2)
    set_req(1, F1, F2, 1'b0);
    set_req(2, F8, F2, 1'b1);
    out_ready = 1'b0;
    req_valid = 4'b0110;
    tick();
    req_valid = 4'b0100;
    check("bp_first_id", 32'(out_id), 32'd1);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_hold_id", 32'(out_id), 32'd1);
      check("bp_hold_result", out_result, F3);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    check("bp_second_id", 32'(out_id), 32'd2);
    check("bp_second_result", out_result, F6);
    tick();
    check("bp_drain", 32'(out_valid), 32'd0);
    check("bp_busy", 32'(busy), 32'd0);

    // Exceptions from requester 3 and sticky flag behaviour
    set_req(3, NINF, PINF, 1'b0);
    req_valid = 4'b1000;
    tick();
    check("ex_nan_result", out_result, QNAN);
    check("ex_nan_flags", 32'(out_flags), 32'b001);
    check("ex_nan_sticky", 32'(sticky_flags), 32'b001);
    set_req(3, PINF, F3, 1'b0);
    tick();
    check("ex_inf_result", out_result, PINF);
    check("ex_inf_flags", 32'(out_flags), 32'b010);
    check("ex_inf_sticky", 32'(sticky_flags), 32'b011);
    set_req(3, F3, F4, 1'b0);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("ex_clr_result", out_result, F7);
    check("ex_clr_sticky", 32'(sticky_flags), 32'b000);
    set_req(3, NINF, PINF, 1'b0);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("ex_clr_set_sticky", 32'(sticky_flags), 32'b001);
    set_req(3, F3, F3, 1'b1);
    tick();
    check("ex_zero_result", out_result, 32'd0);
    check("ex_zero_sticky", 32'(sticky_flags), 32'b001);
    req_valid = '0;
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("ex_clear_only", 32'(sticky_flags), 32'b000);

    // Sticky flag set again before the reset test
    set_req(3, NINF, PINF, 1'b0);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();

    // Reset while a result is held under backpressure (pointer at 3)
    set_req(0, F3, F4, 1'b0);
    set_req(1, F1, F1, 1'b0);
    out_ready = 1'b0;
    req_valid = 4'b0001;
    tick();
    check("rm_full", 32'(out_valid), 32'd1);
    check("rm_sticky_before", 32'(sticky_flags), 32'b001);
    req_valid = 4'b0011;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rm_valid", 32'(out_valid), 32'd0);
    check("rm_result", out_result, 32'd0);
    check("rm_sticky", 32'(sticky_flags), 32'd0);
    out_ready = 1'b1;
    #1 check("rm_grant", 32'(req_ready), 32'b0001);
    tick();
    check("rm_id", 32'(out_id), 32'd0);
    check("rm_out", out_result, F7);
    req_valid = '0;
    tick();
    check("rm_final_drain", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
